// File: rtl/fsk_demod.sv
// -----------------------------------------------------------------------------
// fsk_demod
//
// Receive-side FSK demodulator. It recovers serial data from a 1-bit
// square-wave FSK line. Each half-period is measured from one edge to the
// next and classed as mark (1) or space (0). Once enough consecutive good
// half-periods have been seen, the carrier counts as locked. While locked,
// each bit window integrates the valid half-period lengths per class. The
// bit is decided at window end.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   fsk_in     - asynchronous FSK square wave from the line
//   bit_out    - last recovered data bit, held between strobes
//   bit_valid  - one-cycle strobe: bit_out carries a new decision this cycle
//   carrier_ok - high while locked to the carrier
//   err        - one-cycle pulse: bad half-period or carrier timeout while locked
// -----------------------------------------------------------------------------
module fsk_demod #(
    parameter int unsigned MARK_HALF  = 4,
    parameter int unsigned SPACE_HALF = 8,
    parameter int unsigned TOL        = 1,
    parameter int unsigned BIT_CYCLES = 32,
    parameter int unsigned LOCK_N     = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic fsk_in,
    output logic bit_out,
    output logic bit_valid,
    output logic carrier_ok,
    output logic err
);

    localparam int unsigned ACC_W   = $clog2(2 * BIT_CYCLES) + 1;
    localparam int unsigned WIN_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned VCNT_W  = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;
    localparam int unsigned SUM_W   = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam int unsigned TIMEOUT = 2 * SPACE_HALF + TOL + 1;

    localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(BIT_CYCLES - 1);
    localparam logic [VCNT_W-1:0] VCNT_TOP = VCNT_W'(LOCK_N - 1);

    localparam logic [CNT_W-1:0] MARK_LO  = CNT_W'(MARK_HALF - TOL);
    localparam logic [CNT_W-1:0] MARK_HI  = CNT_W'(MARK_HALF + TOL);
    localparam logic [CNT_W-1:0] SPACE_LO = CNT_W'(SPACE_HALF - TOL);
    localparam logic [CNT_W-1:0] SPACE_HI = CNT_W'(SPACE_HALF + TOL);

    typedef enum logic {
        StSearch,
        StLocked
    } state_e;

    // Synchronizer and edge detect
    logic s1_q, s2_q, s3_q;
    logic edge_det;

    // Interval measurement
    logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
    logic             seen_q, seen_d;

    // Control and integrators
    state_e            state_q, state_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [ACC_W-1:0]  mark_acc_q, mark_acc_d;
    logic [ACC_W-1:0]  space_acc_q, space_acc_d;
    logic              last_class_q, last_class_d;
    logic              bit_out_q, bit_out_d;

    logic [CNT_W-1:0] len;
    logic             is_mark, is_space, valid_edge, timeout, decision;
    logic [WIN_W-1:0] win_realign;

    // Saturating accumulate of a half-period length.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [CNT_W-1:0] val);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(val);
        if (sum > SUM_W'(ACC_MAX)) begin
            return ACC_MAX;
        end
        return ACC_W'(sum);
    endfunction

    assign edge_det = s2_q ^ s3_q;
    assign len      = int_cnt_q;

    assign is_mark  = (len >= MARK_LO) && (len <= MARK_HI);
    assign is_space = (len >= SPACE_LO) && (len <= SPACE_HI);
    // The first edge after reset measures from an arbitrary point, so it is
    // never valid.
    assign valid_edge = edge_det && seen_q && (is_mark || is_space);
    assign timeout    = !edge_det && (32'(int_cnt_q) == TIMEOUT);

    assign win_realign = (32'(len) >= BIT_CYCLES - 1) ? WIN_LAST : WIN_W'(len);
    // A tie decides 0.
    assign decision    = mark_acc_q > space_acc_q;

    assign carrier_ok = (state_q == StLocked);
    assign bit_valid  = carrier_ok && (win_q == WIN_LAST);
    // Present the fresh decision during the strobe, then hold it.
    assign bit_out    = bit_valid ? decision : bit_out_q;

    always_comb begin
        int_cnt_d    = int_cnt_q;
        seen_d       = seen_q | edge_det;
        state_d      = state_q;
        vcnt_d       = vcnt_q;
        win_d        = win_q;
        mark_acc_d   = mark_acc_q;
        space_acc_d  = space_acc_q;
        last_class_d = last_class_q;
        bit_out_d    = bit_out_q;
        err          = 1'b0;

        if (edge_det) begin
            int_cnt_d = CNT_W'(1);
        end else if (int_cnt_q != CNT_MAX) begin
            int_cnt_d = int_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StSearch: begin
                if (edge_det) begin
                    if (valid_edge) begin
                        if (vcnt_q == VCNT_TOP) begin
                            state_d      = StLocked;
                            vcnt_d       = '0;
                            win_d        = '0;
                            mark_acc_d   = '0;
                            space_acc_d  = '0;
                            last_class_d = is_mark;
                        end else begin
                            vcnt_d = vcnt_q + VCNT_W'(1);
                        end
                    end else begin
                        vcnt_d = '0;
                    end
                end
            end

            StLocked: begin
                win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);

                // Window end decides from what was integrated before this
                // cycle. Any edge in the same cycle belongs to the next window.
                if (bit_valid) begin
                    bit_out_d   = decision;
                    mark_acc_d  = '0;
                    space_acc_d = '0;
                end

                if ((edge_det && !valid_edge) || timeout) begin
                    err     = 1'b1;
                    state_d = StSearch;
                    vcnt_d  = '0;
                end else if (valid_edge) begin
                    if (is_mark != last_class_q) begin
                        // A class change marks a bit boundary at the previous
                        // edge. Restart the window as if it began there.
                        win_d        = win_realign;
                        last_class_d = is_mark;
                        if (is_mark) begin
                            mark_acc_d  = sat_add('0, len);
                            space_acc_d = '0;
                        end else begin
                            mark_acc_d  = '0;
                            space_acc_d = sat_add('0, len);
                        end
                    end else if (is_mark) begin
                        mark_acc_d = sat_add(mark_acc_d, len);
                    end else begin
                        space_acc_d = sat_add(space_acc_d, len);
                    end
                end
            end

            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            int_cnt_q    <= '0;
            seen_q       <= 1'b0;
            state_q      <= StSearch;
            vcnt_q       <= '0;
            win_q        <= '0;
            mark_acc_q   <= '0;
            space_acc_q  <= '0;
            last_class_q <= 1'b0;
            bit_out_q    <= 1'b0;
        end else begin
            s1_q         <= fsk_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            int_cnt_q    <= int_cnt_d;
            seen_q       <= seen_d;
            state_q      <= state_d;
            vcnt_q       <= vcnt_d;
            win_q        <= win_d;
            mark_acc_q   <= mark_acc_d;
            space_acc_q  <= space_acc_d;
            last_class_q <= last_class_d;
            bit_out_q    <= bit_out_d;
        end
    end

endmodule
